can_tx_buffer: RTL and testbench
================================

// Module: can_tx_buffer
// PURPOSE
//  Transmit-side frame buffer of the CAN controller; the counterpart of the RX FIFO.
//  - Host writes the 13-byte TX buffer through the register port.
//  - On transmit request, locks the buffer and streams the frame byte-by-byte to the bit-stream engine.
//  - Retries on arbitration loss or bus error; reports SJA1000-style TX status and a completion pulse.
// PARAMETERS
//  U_DLY      1  simulation delay on non-blocking assignments
//  MAX_RETRY  15 retry attempts before giving up (used only with CAN_TX_RETRY_LIMIT_EN)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active-high
//  wr             in   1  host register write strobe
//  addr           in   6  host register address
//  data_in        in   8  host write data
//  tx_selected    in   1  addr decodes to a TX-buffer register
//  reset_mode     in   1  controller reset mode
//  extended_mode  in   1  1 = PeliCAN map (addr 16..28), 0 = BasicCAN map (addr 10..19)
//  tx_request     in   1  transmit-request command pulse
//  abort_tx       in   1  abort-transmission command pulse
//  tx_byte_ready  in   1  engine accepts tx_byte this cycle
//  tx_frame_ok    in   1  engine pulse: frame sent and acknowledged
//  tx_arb_lost    in   1  engine pulse: arbitration lost
//  tx_error       in   1  engine pulse: error frame during transmission
//  data_out       out  8  readback of buffer byte at addr, registered (1-cycle latency)
//  tx_byte        out  8  frame byte to engine
//  tx_byte_valid  out  1  tx_byte valid
//  tx_byte_last   out  1  tx_byte is the final byte of the frame
//  tx_buf_status  out  1  1 = buffer released, host may write
//  tx_complete    out  1  1 = last requested transmission completed successfully
//  tx_in_progress out  1  frame currently owned by the engine
//  tx_done_pulse  out  1  one-cycle pulse when a request finishes (ok, aborted or given up)
// BEHAVIOUR
//  Reset (rst or reset_mode):
//  - state=IDLE; tx_buf_status=1; tx_complete=1; tx_in_progress=0.
//  - tx_byte_valid=0; tx_done_pulse=0; data_out=0; buffer contents undefined.
//  Writes:
//  - Stored when wr & tx_selected & tx_buf_status; ignored while locked.
//  - Index = addr-16 (ext) or addr-10 (basic).
//  - Index >12 (ext) or >9 (basic) is ignored.
//  Frame length:
//  - ext: 1 + (FF ? 4 : 2) + (RTR ? 0 : min(DLC,8)), where byte0 = {FF,RTR,2'b0,DLC}.
//  - basic: 2 + (RTR ? 0 : min(DLC,8)), where byte1 = {ID[2:0],RTR,DLC}.
//  - DLC 9..15 clamps to 8 data bytes.
//  FSM IDLE->LOAD->SEND->WAIT->DONE->IDLE:
//  - IDLE: tx_request -> LOAD; tx_buf_status<=0, tx_complete<=0, tx_in_progress<=1.
//  - LOAD: latch frame length into a 4-bit register; byte index<=0; -> SEND.
//    tx_byte_valid is first asserted 2 cycles after tx_request.
//  - SEND: tx_byte = buf[index]; on valid & ready, index++.
//    tx_byte_last = (index == len-1); the transfer of the last byte -> WAIT.
//    tx_byte must stay stable while valid & ~ready.
//  - WAIT: tx_frame_ok -> DONE with tx_complete<=1.
//  - SEND/WAIT: tx_arb_lost|tx_error -> LOAD (retry from byte 0), or -> DONE with tx_complete=0
//    if an abort is pending.
//  - DONE: tx_done_pulse=1, tx_buf_status<=1, tx_in_progress<=0 -> IDLE.
//  Abort:
//  - abort_tx in SEND/WAIT sets abort_pend; it never truncates a frame on the bus.
//  - abort_tx in IDLE or DONE is ignored. abort_pend is cleared in DONE.
//  Simultaneous events:
//  - tx_frame_ok together with arb_lost/error: tx_frame_ok wins.
//  - tx_request outside IDLE is ignored.
//  - reset_mode mid-frame: immediate IDLE, no tx_done_pulse.
// CONFIGURATION
//  CAN_TX_RETRY_LIMIT_EN
//  - Defined: a 4-bit retry counter, cleared in LOAD-from-IDLE, increments on each arb_lost/error.
//    Reaching MAX_RETRY -> DONE with tx_complete=0.
//  - Undefined: unlimited retries; only abort stops retransmission.
// STRUCTURE
//  Shared package can_pkg:
//  - TX FSM state encoding.
//  - TX_BASE_EXT=16, TX_BASE_BASIC=10.
//  - TX_BUF_BYTES=13, CAN_MAX_DATA=8.
//  Sub-module can_tx_frame_len: combinational length decode (mode, info bytes) -> 4-bit length.
//  Buffer: 13x8 register array.
// TESTING
//  1. Ext SFF, DLC=2, data AA,BB, request, ready=1 -> bytes {02,id0,id1,AA,BB};
//     last on 5th byte; frame_ok -> tx_done_pulse, tx_complete=1.
//  2. Ext EFF RTR DLC=8 -> exactly 5 bytes.
//     Basic DLC=15 -> 10 bytes, clamped to 8 data.
//  3. arb_lost after byte 3 -> restart at byte 0; frame_ok on second attempt -> tx_complete=1.
//  4. abort_tx during SEND, then tx_error -> DONE; tx_complete=0, tx_buf_status=1, no retry.
//  5. Host write while locked -> buffer unchanged (readback).
//     ready held low 5 cycles -> tx_byte stable.
//  6. reset_mode mid-SEND -> tx_byte_valid=0 next cycle, tx_buf_status=1, tx_complete=1.
//     With CAN_TX_RETRY_LIMIT_EN, 15 errors -> give up.

Source files
------------

// File: rtl/can_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN controller transmit path:
//   - tx_state_t     : TX buffer FSM state encoding
//   - TX_BASE_*      : first host register address of the TX buffer per map
//   - TX_LAST_*      : highest valid buffer index per map
//   - TX_BUF_BYTES   : size of the TX buffer in bytes
//   - CAN_MAX_DATA   : largest number of data bytes a classic CAN frame carries
//   - tx_buf_offset(): host address -> buffer index (out-of-range wraps high)
// -----------------------------------------------------------------------------
package can_pkg;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_LOAD = 3'd1,
        TX_SEND = 3'd2,
        TX_WAIT = 3'd3,
        TX_DONE = 3'd4
    } tx_state_t;

    localparam logic [5:0] TX_BASE_EXT   = 6'd16;
    localparam logic [5:0] TX_BASE_BASIC = 6'd10;
    localparam logic [5:0] TX_LAST_EXT   = 6'd12;
    localparam logic [5:0] TX_LAST_BASIC = 6'd9;
    localparam int         TX_BUF_BYTES  = 13;
    localparam logic [3:0] CAN_MAX_DATA  = 4'd8;

    // Addresses below the base wrap to a large offset and fail the range check.
    function automatic logic [5:0] tx_buf_offset(input logic [5:0] addr, input logic ext);
        return ext ? (addr - TX_BASE_EXT) : (addr - TX_BASE_BASIC);
    endfunction

endpackage

// File: rtl/can_tx_frame_len.sv
// -----------------------------------------------------------------------------
// can_tx_frame_len
// Combinational frame-length decode for the TX buffer.
//   extended_mode in  1  1 = PeliCAN layout (info in byte 0), 0 = BasicCAN (info in byte 1)
//   info0         in  8  buffer byte 0  (PeliCAN: {FF,RTR,2'b0,DLC})
//   info1         in  8  buffer byte 1  (BasicCAN: {ID[2:0],RTR,DLC})
//   frame_len     out 4  total number of bytes to stream for this frame
// -----------------------------------------------------------------------------
module can_tx_frame_len
    import can_pkg::*;
(
    input  logic       extended_mode,
    input  logic [7:0] info0,
    input  logic [7:0] info1,
    output logic [3:0] frame_len
);

    logic [3:0] dlc;
    logic       rtr;
    logic [3:0] hdr_len;
    logic [3:0] data_len;

    always_comb begin
        if (extended_mode) begin
            dlc     = info0[3:0];
            rtr     = info0[6];
            // info byte plus a 4-byte (EFF) or 2-byte (SFF) identifier
            hdr_len = info0[7] ? 4'd5 : 4'd3;
        end else begin
            dlc     = info1[3:0];
            rtr     = info1[4];
            hdr_len = 4'd2;
        end

        // Remote frames carry no data; DLC 9..15 still means 8 data bytes.
        if (rtr)
            data_len = 4'd0;
        else if (dlc > CAN_MAX_DATA)
            data_len = CAN_MAX_DATA;
        else
            data_len = dlc;

        frame_len = hdr_len + data_len;
    end

endmodule

// File: rtl/can_tx_buffer.sv
// -----------------------------------------------------------------------------
// can_tx_buffer
// Transmit-side frame buffer of the CAN controller. The host fills a 13-byte
// buffer through the register port; a transmit request locks it and streams
// the frame byte-by-byte to the bit-stream engine, retrying after arbitration
// loss or bus error until the frame is acknowledged or an abort is pending.
//
// Build option: define CAN_TX_RETRY_LIMIT_EN to give up after MAX_RETRY
// failed attempts; without it retries are unlimited and only abort stops them.
//
// Ports:
//   clk, rst (async, active-high)     clock / reset
//   wr, addr, data_in, tx_selected    host register write port
//   data_out                          registered readback of buffer byte at addr
//   reset_mode, extended_mode         controller mode (reset / PeliCAN map)
//   tx_request, abort_tx              command pulses
//   tx_byte, tx_byte_valid,
//   tx_byte_last, tx_byte_ready       byte stream to the engine
//   tx_frame_ok, tx_arb_lost, tx_error engine result pulses
//   tx_buf_status, tx_complete,
//   tx_in_progress, tx_done_pulse     SJA1000-style TX status
// -----------------------------------------------------------------------------
module can_tx_buffer
    import can_pkg::*;
#(
    parameter int U_DLY     = 1,
    parameter int MAX_RETRY = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [5:0] addr,
    input  logic [7:0] data_in,
    input  logic       tx_selected,
    input  logic       reset_mode,
    input  logic       extended_mode,
    input  logic       tx_request,
    input  logic       abort_tx,
    input  logic       tx_byte_ready,
    input  logic       tx_frame_ok,
    input  logic       tx_arb_lost,
    input  logic       tx_error,
    output logic [7:0] data_out,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    output logic       tx_byte_last,
    output logic       tx_buf_status,
    output logic       tx_complete,
    output logic       tx_in_progress,
    output logic       tx_done_pulse
);

    if (U_DLY < 0 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_param_check
        $error("can_tx_buffer: U_DLY must be >= 0 and MAX_RETRY within 1..15");
    end

    logic [7:0] tx_buf [TX_BUF_BYTES];
    tx_state_t  state;
    logic [3:0] len_dec;
    logic [3:0] len_q;
    logic [3:0] byte_idx;
    logic       abort_pend;
    logic [5:0] host_idx;
    logic       host_idx_ok;
    logic       retry_evt;
    logic       give_up;
    logic       retry_exhausted;

    assign host_idx    = tx_buf_offset(addr, extended_mode);
    assign host_idx_ok = extended_mode ? (host_idx <= TX_LAST_EXT) : (host_idx <= TX_LAST_BASIC);

    // Buffer contents are not reset; the host always rewrites before a request.
    always_ff @(posedge clk) begin
        if (wr && tx_selected && tx_buf_status && host_idx_ok)
            tx_buf[host_idx[3:0]] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_out <= 8'h00;
        else if (reset_mode)
            data_out <= 8'h00;
        else if (tx_selected && host_idx_ok)
            data_out <= tx_buf[host_idx[3:0]];
        else
            data_out <= 8'h00;
    end

    can_tx_frame_len u_frame_len (
        .extended_mode (extended_mode),
        .info0         (tx_buf[0]),
        .info1         (tx_buf[1]),
        .frame_len     (len_dec)
    );

    // The buffer is locked while streaming, so tx_byte holds while ready is low.
    assign tx_byte      = tx_buf[byte_idx];
    assign tx_byte_last = (state == TX_SEND) && (byte_idx == len_q - 4'd1);

    // A frame_ok in WAIT outranks a simultaneous arbitration loss / error.
    assign retry_evt = (tx_arb_lost || tx_error) &&
                       ((state == TX_SEND) || (state == TX_WAIT && !tx_frame_ok));

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic [3:0] retry_cnt;
    assign retry_exhausted = (retry_cnt == 4'(MAX_RETRY - 1));
`else
    assign retry_exhausted = 1'b0;
`endif

    // An abort arriving in the same cycle as the failure counts as pending.
    assign give_up = abort_pend || abort_tx || retry_exhausted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= TX_IDLE;
            tx_buf_status  <= 1'b1;
            tx_complete    <= 1'b1;
            tx_in_progress <= 1'b0;
            tx_byte_valid  <= 1'b0;
            tx_done_pulse  <= 1'b0;
            abort_pend     <= 1'b0;
            len_q          <= 4'd0;
            byte_idx       <= 4'd0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            retry_cnt      <= 4'd0;
`endif
        end else if (reset_mode) begin
            // Controller reset mode drops any frame silently (no done pulse).
            state          <= TX_IDLE;
            tx_buf_status  <= 1'b1;
            tx_complete    <= 1'b1;
            tx_in_progress <= 1'b0;
            tx_byte_valid  <= 1'b0;
            tx_done_pulse  <= 1'b0;
            abort_pend     <= 1'b0;
            len_q          <= 4'd0;
            byte_idx       <= 4'd0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            retry_cnt      <= 4'd0;
`endif
        end else begin
            tx_done_pulse <= 1'b0;

            if ((state == TX_SEND || state == TX_WAIT) && abort_tx)
                abort_pend <= 1'b1;

            case (state)
                TX_IDLE: begin
                    if (tx_request) begin
                        state          <= TX_LOAD;
                        tx_buf_status  <= 1'b0;
                        tx_complete    <= 1'b0;
                        tx_in_progress <= 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
                        retry_cnt      <= 4'd0;
`endif
                    end
                end
                TX_LOAD: begin
                    len_q         <= len_dec;
                    byte_idx      <= 4'd0;
                    tx_byte_valid <= 1'b1;
                    state         <= TX_SEND;
                end
                TX_SEND: begin
                    if (tx_byte_valid && tx_byte_ready) begin
                        if (tx_byte_last) begin
                            tx_byte_valid <= 1'b0;
                            state         <= TX_WAIT;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end
                TX_WAIT: begin
                    if (tx_frame_ok) begin
                        tx_complete   <= 1'b1;
                        tx_done_pulse <= 1'b1;
                        state         <= TX_DONE;
                    end
                end
                TX_DONE: begin
                    tx_buf_status  <= 1'b1;
                    tx_in_progress <= 1'b0;
                    abort_pend     <= 1'b0;
                    state          <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase

            // Failure handling overrides the SEND/WAIT updates above.
            if (retry_evt) begin
                tx_byte_valid <= 1'b0;
                if (give_up) begin
                    state         <= TX_DONE;
                    tx_done_pulse <= 1'b1;
                end else begin
                    state <= TX_LOAD;
                end
`ifdef CAN_TX_RETRY_LIMIT_EN
                retry_cnt <= retry_cnt + 4'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_can_tx_buffer.sv
`timescale 1ns/1ps
module tb_can_tx_buffer;

    logic       clk = 1'b0;
    logic       rst, wr, tx_selected, reset_mode, extended_mode;
    logic [5:0] addr;
    logic [7:0] data_in;
    logic       tx_request, abort_tx, tx_byte_ready, tx_frame_ok, tx_arb_lost, tx_error;
    logic [7:0] data_out, tx_byte;
    logic       tx_byte_valid, tx_byte_last, tx_buf_status, tx_complete, tx_in_progress, tx_done_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mbuf [13];

    typedef struct {
        bit         ext;
        logic [7:0] info;
        int         len;
        int         lose;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    can_tx_buffer dut (
        .clk(clk), .rst(rst), .wr(wr), .addr(addr), .data_in(data_in),
        .tx_selected(tx_selected), .reset_mode(reset_mode), .extended_mode(extended_mode),
        .tx_request(tx_request), .abort_tx(abort_tx), .tx_byte_ready(tx_byte_ready),
        .tx_frame_ok(tx_frame_ok), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error),
        .data_out(data_out), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
        .tx_byte_last(tx_byte_last), .tx_buf_status(tx_buf_status), .tx_complete(tx_complete),
        .tx_in_progress(tx_in_progress), .tx_done_pulse(tx_done_pulse)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Frame length straight from the CAN frame rules.
    function automatic int model_len(input bit ext, input logic [7:0] b0, input logic [7:0] b1);
        int dlc, ndata;
        if (ext) begin
            dlc   = int'(b0[3:0]);
            ndata = b0[6] ? 0 : (dlc > 8 ? 8 : dlc);
            return 1 + (b0[7] ? 4 : 2) + ndata;
        end
        dlc   = int'(b1[3:0]);
        ndata = b1[4] ? 0 : (dlc > 8 ? 8 : dlc);
        return 2 + ndata;
    endfunction

    task automatic host_write(input bit ext, input int idx, input logic [7:0] val, input bit open);
        extended_mode = ext;
        addr          = 6'((ext ? 16 : 10) + idx);
        data_in       = val;
        wr            = 1'b1;
        tx_selected   = 1'b1;
        tick();
        wr          = 1'b0;
        tx_selected = 1'b0;
        if (open && idx >= 0 && idx <= (ext ? 12 : 9))
            mbuf[idx] = val;
    endtask

    task automatic readback(input bit ext, input int idx, input string name);
        extended_mode = ext;
        addr          = 6'((ext ? 16 : 10) + idx);
        tx_selected   = 1'b1;
        tick();
        chk(name, data_out, mbuf[idx]);
        tx_selected = 1'b0;
    endtask

    task automatic load_frame(input bit ext, input logic [7:0] info);
        logic [7:0] v;
        for (int i = 0; i <= (ext ? 12 : 9); i++) begin
            v = 8'($urandom);
            if (ext && i == 0) v = info;
            if (!ext && i == 1) v = info;
            host_write(ext, i, v, 1'b1);
        end
    endtask

    // Streams one frame; lose_after = bytes accepted before an injected
    // arbitration loss (-1 for none), after which the frame restarts at byte 0.
    task automatic stream(input int len, input int lose_after, input int rdy_pct,
                          input int start_k, input bit do_req);
        int k, cyc;
        bit lost;
        k = start_k; cyc = 0; lost = (lose_after < 0);
        if (do_req) begin
            tx_request = 1'b1; tick(); tx_request = 1'b0;
            chk("req_valid_low", tx_byte_valid, 0);
            chk("req_buf_locked", tx_buf_status, 0);
            chk("req_in_progress", tx_in_progress, 1);
            chk("req_complete_low", tx_complete, 0);
            tick();
            chk("req_valid_2cyc", tx_byte_valid, 1);
        end
        while ((k < len || !lost) && cyc < 600) begin
            cyc++;
            if (!lost && k == lose_after) begin
                tx_byte_ready = 1'b0; tx_arb_lost = 1'b1; tick(); tx_arb_lost = 1'b0;
                chk("arb_valid_drop", tx_byte_valid, 0);
                tick();
                chk("arb_restart_valid", tx_byte_valid, 1);
                k = 0; lost = 1'b1;
            end else begin
                tx_byte_ready = ($urandom_range(99) < rdy_pct);
                if (tx_byte_valid && tx_byte_ready) begin
                    chk("tx_byte", tx_byte, mbuf[k]);
                    chk("tx_last", tx_byte_last, (k == len - 1));
                    k++;
                end
                tick();
            end
        end
        tx_byte_ready = 1'b0;
        chk("stream_len", k, len);
        chk("wait_valid_low", tx_byte_valid, 0);
    endtask

    task automatic finish_ok();
        tx_frame_ok = 1'b1; tick(); tx_frame_ok = 1'b0;
        chk("ok_done_pulse", tx_done_pulse, 1);
        chk("ok_complete", tx_complete, 1);
        tick();
        chk("ok_pulse_single", tx_done_pulse, 0);
        chk("ok_buf_released", tx_buf_status, 1);
        chk("ok_in_progress_low", tx_in_progress, 0);
    endtask

    initial begin
        bit         r_ext;
        logic [7:0] r_info;
        int         r_len, r_lose;

        rst = 1'b1; wr = 1'b0; addr = '0; data_in = '0; tx_selected = 1'b0;
        reset_mode = 1'b0; extended_mode = 1'b1; tx_request = 1'b0; abort_tx = 1'b0;
        tx_byte_ready = 1'b0; tx_frame_ok = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
        foreach (mbuf[i]) mbuf[i] = 8'h00;

        tbl[0] = '{ext: 1'b1, info: 8'h02, len: 5,  lose: -1};  // SFF DLC2
        tbl[1] = '{ext: 1'b1, info: 8'hC8, len: 5,  lose: -1};  // EFF RTR DLC8
        tbl[2] = '{ext: 1'b0, info: 8'hAF, len: 10, lose: -1};  // basic DLC15 clamps
        tbl[3] = '{ext: 1'b1, info: 8'h02, len: 5,  lose: 3};   // arb lost after byte 3
        tbl[4] = '{ext: 1'b1, info: 8'h88, len: 13, lose: -1};  // EFF DLC8, full buffer
        tbl[5] = '{ext: 1'b1, info: 8'h00, len: 3,  lose: 0};   // SFF DLC0
        tbl[6] = '{ext: 1'b0, info: 8'h13, len: 2,  lose: -1};  // basic RTR
        tbl[7] = '{ext: 1'b1, info: 8'h0C, len: 11, lose: 11};  // DLC12, lost while waiting

        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_buf_status", tx_buf_status, 1);
        chk("rst_complete", tx_complete, 1);
        chk("rst_in_progress", tx_in_progress, 0);
        chk("rst_valid", tx_byte_valid, 0);
        chk("rst_done_pulse", tx_done_pulse, 0);
        chk("rst_data_out", data_out, 0);

        // Abort while idle must not leave anything pending.
        abort_tx = 1'b1; tick(); abort_tx = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load_frame(tbl[i].ext, tbl[i].info);
            stream(tbl[i].len, tbl[i].lose, (i % 2) ? 60 : 100, 0, 1'b1);
            finish_ok();
        end

        // Stall with ready low and attempt writes while locked.
        load_frame(1'b1, 8'h08);
        tx_request = 1'b1; tick(); tx_request = 1'b0; tick();
        tx_byte_ready = 1'b1; tick(); tx_byte_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", tx_byte_valid, 1);
            chk("stall_byte", tx_byte, mbuf[1]);
            if (c == 1)      host_write(1'b1, 1, ~mbuf[1], 1'b0);
            else if (c == 3) host_write(1'b1, 5, ~mbuf[5], 1'b0);
            else             tick();
        end
        stream(11, -1, 100, 1, 1'b0);
        finish_ok();
        readback(1'b1, 1, "locked_write_1");
        readback(1'b1, 5, "locked_write_5");

        // Abort during SEND, then bus error: finish without retry.
        load_frame(1'b0, 8'h28);
        tx_request = 1'b1; tick(); tx_request = 1'b0; tick();
        tx_byte_ready = 1'b1; tick(); tick(); tx_byte_ready = 1'b0;
        abort_tx = 1'b1; tick(); abort_tx = 1'b0;
        tick();
        chk("abort_no_truncate", tx_byte_valid, 1);
        tx_error = 1'b1; tick(); tx_error = 1'b0;
        chk("abort_done_pulse", tx_done_pulse, 1);
        chk("abort_complete", tx_complete, 0);
        tick();
        chk("abort_buf_released", tx_buf_status, 1);
        chk("abort_in_progress", tx_in_progress, 0);
        tick(); tick();
        chk("abort_no_retry", tx_byte_valid, 0);
        chk("abort_complete_hold", tx_complete, 0);

        // reset_mode in the middle of a frame.
        load_frame(1'b1, 8'h02);
        tx_request = 1'b1; tick(); tx_request = 1'b0; tick();
        tx_byte_ready = 1'b1; tick(); tx_byte_ready = 1'b0;
        reset_mode = 1'b1; tick();
        chk("rmode_valid", tx_byte_valid, 0);
        chk("rmode_buf_status", tx_buf_status, 1);
        chk("rmode_complete", tx_complete, 1);
        chk("rmode_in_progress", tx_in_progress, 0);
        chk("rmode_no_pulse", tx_done_pulse, 0);
        chk("rmode_data_out", data_out, 0);
        reset_mode = 1'b0; tick();
        chk("rmode_idle_valid", tx_byte_valid, 0);
        chk("rmode_idle_pulse", tx_done_pulse, 0);

        // Fifteen consecutive errors.
        load_frame(1'b1, 8'h01);
        tx_request = 1'b1; tick(); tx_request = 1'b0; tick();
        for (int e = 1; e <= 15; e++) begin
            tx_error = 1'b1; tick(); tx_error = 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            if (e == 15) break;
`endif
            tick();
            chk("retry_resend", tx_byte_valid, 1);
        end
`ifdef CAN_TX_RETRY_LIMIT_EN
        chk("giveup_pulse", tx_done_pulse, 1);
        chk("giveup_complete", tx_complete, 0);
`else
        abort_tx = 1'b1; tick(); abort_tx = 1'b0;
        tx_error = 1'b1; tick(); tx_error = 1'b0;
        chk("retry_abort_pulse", tx_done_pulse, 1);
        chk("retry_abort_complete", tx_complete, 0);
`endif
        tick();
        chk("retry_end_released", tx_buf_status, 1);

        // Out-of-range BasicCAN write (index 10) is dropped.
        load_frame(1'b1, 8'h00);
        host_write(1'b0, 10, ~mbuf[10], 1'b1);
        readback(1'b1, 10, "basic_range_ignored");
        readback(1'b0, 1, "basic_readback");

        // Randomised frames against the model.
        for (int r = 0; r < 24; r++) begin
            r_ext  = 1'($urandom_range(1));
            r_info = 8'($urandom);
            load_frame(r_ext, r_info);
            r_len  = model_len(r_ext, mbuf[0], mbuf[1]);
            r_lose = ($urandom_range(2) == 0) ? int'($urandom_range(r_len)) : -1;
            stream(r_len, r_lose, int'($urandom_range(100, 30)), 0, 1'b1);
            finish_ok();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
